// File: rtl/sha256_msg_schedule_pkg.sv
// sha256_msg_schedule_pkg: shared widths, state encodings, FIPS 180-4 K table and the 32-bit CLA adder.
package sha256_msg_schedule_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [WORD_W-1:0] K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Kogge-Stone prefix carry network; sum is modulo 2^32.
    function automatic logic [WORD_W-1:0] cla_add32(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] g, p;
        g = a & b;
        p = a ^ b;
        for (int d = 1; d < WORD_W; d = d * 2)
            for (int i = WORD_W - 1; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        return (a ^ b) ^ {g[WORD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_sigma.sv
// sha256_msg_sigma: combinational SHA-256 small sigma functions, s0 = sigma0(x0), s1 = sigma1(x1).
module sha256_msg_sigma
    import sha256_msg_schedule_pkg::*;
(
    input  logic [WORD_W-1:0] x0,
    input  logic [WORD_W-1:0] x1,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    assign s0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
    assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message-schedule generator, 16 words in, W[0..63] out with a one-word output slot.
// Define SHA256_SCHED_KT_EN to register K[t] on kt_data; otherwise kt_data is 0.
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              win_valid,
    input  logic [WORD_W-1:0] win_data,
    output logic              win_ready,
    output logic              wt_valid,
    output logic [WORD_W-1:0] wt_data,
    output logic [5:0]        wt_index,
    output logic [WORD_W-1:0] kt_data,
    input  logic              wt_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    logic [1:0]        state_q, state_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] w_q [16];
    logic [WORD_W-1:0] w_d [16];
    logic              wt_valid_q, wt_valid_d;
    logic [WORD_W-1:0] wt_data_q, wt_data_d;
    logic [5:0]        wt_index_q, wt_index_d;
    logic [WORD_W-1:0] s0, s1, sum_a, sum_b, w_exp, w_new;
    logic              slot_free, ld_in, ld_ex, ld;

    sha256_msg_sigma u_sigma (
        .x0 (w_q[1]),
        .x1 (w_q[14]),
        .s0 (s0),
        .s1 (s1)
    );

    assign sum_a = cla_add32(s1, w_q[9]);
    assign sum_b = cla_add32(s0, w_q[0]);
    assign w_exp = cla_add32(sum_a, sum_b);

    assign slot_free = !wt_valid_q || wt_ready;
    assign win_ready = (state_q == S_LOAD) && slot_free;
    assign ld_in     = win_valid && win_ready;
    assign ld_ex     = (state_q == S_EXPAND) && slot_free;
    assign ld        = ld_in || ld_ex;
    assign w_new     = ld_in ? win_data : w_exp;

    assign wt_valid = wt_valid_q;
    assign wt_data  = wt_data_q;
    assign wt_index = wt_index_q;
    assign busy     = state_q != S_IDLE;
    // done marks the cycle in which the consumer takes W[63]
    assign done     = (state_q == S_DONE) && slot_free;

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        w_d        = w_q;
        wt_valid_d = wt_valid_q && !slot_free;
        wt_data_d  = wt_data_q;
        wt_index_d = wt_index_q;
        if (ld) begin
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15]    = w_new;
            wt_valid_d = 1'b1;
            wt_data_d  = w_new;
            wt_index_d = t_q;
            t_d        = (t_q == LAST_T) ? t_q : t_q + 6'd1;
        end
        case (state_q)
            S_IDLE:   if (start) begin state_d = S_LOAD; t_d = '0; end
            S_LOAD:   if (ld_in && t_q == 6'd15) state_d = S_EXPAND;
            S_EXPAND: if (ld_ex && t_q == LAST_T) state_d = S_DONE;
            default:  if (slot_free) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            wt_valid_q <= 1'b0;
            wt_data_q  <= '0;
            wt_index_q <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            w_q        <= w_d;
            wt_valid_q <= wt_valid_d;
            wt_data_q  <= wt_data_d;
            wt_index_q <= wt_index_d;
        end

`ifdef SHA256_SCHED_KT_EN
    logic [WORD_W-1:0] kt_q, kt_d;
    assign kt_d    = ld ? K[t_q] : kt_q;
    assign kt_data = kt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) kt_q <= '0;
        else     kt_q <= kt_d;
`else
    assign kt_data = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: scoreboard bench for the SHA-256 message schedule generator.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        win_valid = 1'b0;
    logic [31:0] win_data = '0;
    logic        win_ready;
    logic        wt_valid;
    logic [31:0] wt_data;
    logic [5:0]  wt_index;
    logic [31:0] kt_data;
    logic        wt_ready = 1'b0;
    logic        busy;
    logic        done;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .win_valid (win_valid),
        .win_data  (win_data),
        .win_ready (win_ready),
        .wt_valid  (wt_valid),
        .wt_data   (wt_data),
        .wt_index  (wt_index),
        .kt_data   (kt_data),
        .wt_ready  (wt_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] m_abc [16];
    logic [31:0] m_rnd [16];
    logic [31:0] got [64];
    logic [31:0] kt_got [64];
    logic [31:0] ref_w [64];
    logic [31:0] exp_q [$];
    int          done_cyc, ndone, nout;
    logic        busy1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Drives one block; pushes expected words as inputs are accepted and pops them as outputs are taken.
    task automatic run_block(input logic [31:0] m [16], input int bp, input int gap, input int start_at, input int rst_at);
        logic [31:0] w [64];
        logic [31:0] held, e;
        logic [5:0]  held_i;
        logic        in_acc, out_acc, stall;
        int          idx, cyc;
        for (int t = 0; t < 64; t++) w[t] = (t < 16) ? m[t] : sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
        exp_q.delete();
        idx = 0; cyc = 0; nout = 0; ndone = 0; done_cyc = -1; busy1 = 1'b0; stall = 1'b0;
        held = '0; held_i = '0;
        forever begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if (wt_valid !== 1'b1 || wt_data !== held || wt_index !== held_i)
                    $display("FAIL stall_hold: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d", wt_valid, wt_data, wt_index, held, held_i);
                else passed++;
            end
            start     = (cyc == 0) || (start_at >= 0 && nout == start_at);
            win_valid = (idx < 16) ? ($urandom_range(99) >= gap) : 1'($urandom_range(1));
            win_data  = (idx < 16) ? m[idx] : $urandom;
            wt_ready  = $urandom_range(99) >= bp;
            if (rst_at >= 0 && nout == rst_at) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({win_ready, wt_valid, busy, done} !== 4'b0 || wt_data !== '0 || wt_index !== '0 || kt_data !== '0)
                    $display("FAIL reset_abort: got rdy=%b v=%b busy=%b done=%b d=%h i=%0d k=%h expected all 0",
                             win_ready, wt_valid, busy, done, wt_data, wt_index, kt_data);
                else passed++;
                @(posedge clk);
                #1 rst = 1'b0;
                break;
            end
            #1;
            in_acc  = win_valid && win_ready;
            out_acc = wt_valid && wt_ready;
            if (out_acc) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                if (nout > 63 || wt_data !== e || wt_index !== 6'(nout))
                    $display("FAIL w_out[%0d]: got d=%h i=%0d expected d=%h i=%0d", nout, wt_data, wt_index, e, 6'(nout));
                else passed++;
                if (nout < 64) begin got[nout] = wt_data; kt_got[nout] = kt_data; end
                nout++;
            end
            stall  = wt_valid && !wt_ready;
            held   = wt_data;
            held_i = wt_index;
            if (in_acc) begin
                if (idx < 16) begin
                    exp_q.push_back(m[idx]);
                    idx++;
                    if (idx == 16) for (int t = 16; t < 64; t++) exp_q.push_back(w[t]);
                end else begin
                    checks++;
                    $display("FAIL spurious_accept: got win_ready=1 expected 0 outside LOAD");
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) busy1 = busy;
            if (done) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
            if ((done_cyc >= 0 && cyc > done_cyc + 3) || cyc > 3000) break;
        end
        start = 1'b0; win_valid = 1'b0; wt_ready = 1'b0;
        if (rst_at < 0) begin
            checks++;
            if (nout !== 64 || done_cyc < 0)
                $display("FAIL block_complete: got outputs=%0d done_cyc=%0d expected 64 outputs and done", nout, done_cyc);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({win_ready, wt_valid, busy, done} !== 4'b0 || wt_data !== '0 || wt_index !== '0 || kt_data !== '0)
            $display("FAIL reset_state: got rdy=%b v=%b busy=%b done=%b d=%h i=%0d k=%h expected all 0",
                     win_ready, wt_valid, busy, done, wt_data, wt_index, kt_data);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_abc;
        run_block(m_abc, 0, 0, -1, -1);
        checks++;
        if (got[16] !== 32'h61626380 || got[17] !== 32'h000F0000 || got[18] !== 32'h7DA86405)
            $display("FAIL abc_w16_18: got %h %h %h expected 61626380 000f0000 7da86405", got[16], got[17], got[18]);
        else passed++;
        checks++;
        if (done_cyc !== 65 || ndone !== 1)
            $display("FAIL abc_done_timing: got cycle=%0d pulses=%0d expected cycle=65 pulses=1", done_cyc, ndone);
        else passed++;
        checks++;
        if (busy1 !== 1'b1) $display("FAIL busy_after_start: got %b expected 1", busy1);
        else passed++;
        ref_w = got;
    endtask

    task automatic test_backpressure;
        run_block(m_abc, 50, 0, -1, -1);
        checks++;
        if (got !== ref_w || ndone !== 1)
            $display("FAIL backpressure_seq: got w63=%h pulses=%0d expected w63=%h pulses=1", got[63], ndone, ref_w[63]);
        else passed++;
    endtask

    task automatic test_gapped_load;
        logic ok;
        for (int i = 0; i < 16; i++) m_rnd[i] = $urandom;
        run_block(m_rnd, 20, 60, -1, -1);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (got[i] !== m_rnd[i]) ok = 1'b0;
        checks++;
        if (!ok || ndone !== 1)
            $display("FAIL gapped_load: got w0=%h w15=%h pulses=%0d expected w0=%h w15=%h pulses=1",
                     got[0], got[15], ndone, m_rnd[0], m_rnd[15]);
        else passed++;
    endtask

    task automatic test_start_in_expand;
        run_block(m_abc, 0, 0, 20, -1);
        checks++;
        if (got !== ref_w || ndone !== 1 || done_cyc !== 65)
            $display("FAIL start_in_expand: got w63=%h pulses=%0d cycle=%0d expected w63=%h pulses=1 cycle=65",
                     got[63], ndone, done_cyc, ref_w[63]);
        else passed++;
    endtask

    task automatic test_reset_mid;
        run_block(m_abc, 0, 0, -1, 30);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ndone !== 0 || busy !== 1'b0 || wt_valid !== 1'b0)
            $display("FAIL reset_mid_idle: got pulses=%0d busy=%b v=%b expected 0 0 0", ndone, busy, wt_valid);
        else passed++;
        run_block(m_abc, 0, 0, -1, -1);
        checks++;
        if (got !== ref_w || ndone !== 1)
            $display("FAIL reset_mid_rerun: got w18=%h pulses=%0d expected w18=%h pulses=1", got[18], ndone, ref_w[18]);
        else passed++;
    endtask

    task automatic test_kt;
`ifdef SHA256_SCHED_KT_EN
        checks++;
        if (kt_got[0] !== 32'h428A2F98 || kt_got[63] !== 32'hC67178F2)
            $display("FAIL kt_rom: got k0=%h k63=%h expected 428a2f98 c67178f2", kt_got[0], kt_got[63]);
        else passed++;
`else
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) if (kt_got[i] !== '0) ok = 1'b0;
        checks++;
        if (!ok) $display("FAIL kt_zero: got k0=%h k63=%h expected 0", kt_got[0], kt_got[63]);
        else passed++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_abc[i] = '0;
        m_abc[0]  = 32'h61626380;
        m_abc[15] = 32'h00000018;
        test_reset;
        test_abc;
        test_kt;
        test_backpressure;
        test_gapped_load;
        test_start_in_expand;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
